mips_multicycle_ctrl: RTL and testbench

- Parametrised, sequential successor to the combinational MIPS decoder.
- Multi-cycle FSM that sequences FETCH/DECODE/EXEC/MEM/WRITEBACK for the MIPS-I subset on the Avalon-style memory bus, stalling on waitrequest.
- Runs MULT/DIV in the background with a configurable latency counter.
- Halts on jump to address 0 or on an illegal instruction.
- Sits between the instruction register/register file/ALU datapath and the bus master.

---
 rtl/mips_multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS-I control FSM: sequences fetch/decode/exec/mem/writeback over an
// Avalon-style bus and tracks background MULT/DIV occupancy of HI/LO.
module mips_multicycle_ctrl #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter logic [31:0] HALT_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic        waitrequest,
   output logic        active,
   output logic [2:0]  state,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        muldiv_start,
   output logic        hilo_busy,
   output logic        illegal
);
   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      K_ILL, K_ALU, K_LOAD, K_STORE, K_BR, K_BRL, K_MUL, K_DIV, K_MF, K_MT
   } kind_t;

   localparam logic [5:0] MUL_LOAD = 6'(MULT_CYCLES);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

   state_t     st;
   kind_t      kind;
   logic [4:0] dest;
   logic [5:0] hcnt;
   logic       unused_fields;

   assign state         = st;
   assign hilo_busy     = (hcnt != 6'd0);
   assign unused_fields = ^{instr[25:21], instr[10:6]};

   // instr is stable from DECODE until the next FETCH, so it is decoded live
   always_comb begin
      kind = K_ILL;
      dest = 5'd0;
      case (instr[31:26])
         6'h00: case (instr[5:0])
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B:        begin kind = K_ALU; dest = instr[15:11]; end
            6'h08:               kind = K_BR;
            6'h09:               begin kind = K_BRL; dest = instr[15:11]; end
            6'h10, 6'h12:        begin kind = K_MF;  dest = instr[15:11]; end
            6'h11, 6'h13:        kind = K_MT;
            6'h18, 6'h19:        kind = K_MUL;
            6'h1A, 6'h1B:        kind = K_DIV;
            default:             kind = K_ILL;
         endcase
         6'h01: case (instr[20:16])
            5'h00, 5'h01:        kind = K_BR;
            5'h10, 5'h11:        begin kind = K_BRL; dest = 5'd31; end
            default:             kind = K_ILL;
         endcase
         6'h02, 6'h04, 6'h05, 6'h06, 6'h07: kind = K_BR;
         6'h03:                  begin kind = K_BRL; dest = 5'd31; end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
                                 begin kind = K_ALU; dest = instr[20:16]; end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25:
                                 begin kind = K_LOAD; dest = instr[20:16]; end
         6'h28, 6'h29, 6'h2B:    kind = K_STORE;
         default:                kind = K_ILL;
      endcase
   end

   // bus strobes react to waitrequest in the same cycle, so they are decoded from state
   always_comb begin
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      muldiv_start = 1'b0;
      if (!reset) begin
         case (st)
            S_FETCH: begin
               mem_read = (pc != HALT_ADDR);
               ir_write = (pc != HALT_ADDR) && !waitrequest;
            end
            S_EXEC: case (kind)
               K_BR:         pc_write = 1'b1;
               K_MUL, K_DIV: begin
                  muldiv_start = !hilo_busy;
                  pc_write     = !hilo_busy;
               end
               K_MT:         pc_write = !hilo_busy;
               default:      pc_write = 1'b0;
            endcase
            S_MEM: begin
               mem_read  = (kind == K_LOAD);
               mem_write = (kind == K_STORE);
               pc_write  = (kind == K_STORE) && !waitrequest;
            end
            S_WB: begin
               pc_write  = 1'b1;
               reg_write = (dest != 5'd0);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st      <= S_FETCH;
         active  <= 1'b1;
         illegal <= 1'b0;
         hcnt    <= 6'd0;
      end else begin
         // a new issue reloads the counter even if it would also have decremented
         if (muldiv_start)
            hcnt <= (kind == K_DIV) ? DIV_LOAD : MUL_LOAD;
         else if (hcnt != 6'd0)
            hcnt <= hcnt - 6'd1;

         case (st)
            S_FETCH:
               if (pc == HALT_ADDR) begin
                  st     <= S_HALT;
                  active <= 1'b0;
               end else if (!waitrequest) begin
                  st <= S_DECODE;
               end
            S_DECODE:
               if (kind == K_ILL) begin
                  st      <= S_HALT;
                  active  <= 1'b0;
                  illegal <= 1'b1;
               end else begin
                  st <= S_EXEC;
               end
            S_EXEC: case (kind)
               K_ALU, K_BRL:        st <= S_WB;
               K_LOAD, K_STORE:     st <= S_MEM;
               K_BR:                st <= S_FETCH;
               K_MUL, K_DIV, K_MT:  if (!hilo_busy) st <= S_FETCH;
               K_MF:                if (!hilo_busy) st <= S_WB;
               default: begin
                  st     <= S_HALT;
                  active <= 1'b0;
               end
            endcase
            S_MEM:
               if (!waitrequest) st <= (kind == K_LOAD) ? S_WB : S_FETCH;
            S_WB:    st <= S_FETCH;
            S_HALT:  st <= S_HALT;
            default: begin
               st     <= S_HALT;
               active <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-accurate check of mips_multicycle_ctrl against an instruction-timeline model
// driven by directed cases and random instruction streams.
module tb_mips_multicycle_ctrl;
   localparam int MULT_N = 4;
   localparam int DIV_N  = 32;
   localparam int K_ILL = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3, K_J = 4,
                  K_JL = 5, K_MUL = 6, K_DIV = 7, K_MF = 8, K_MT = 9;

   logic        clk = 1'b0;
   logic        reset, waitrequest;
   logic [31:0] instr, pc;
   logic        active, mem_read, mem_write, ir_write, pc_write, reg_write;
   logic        muldiv_start, hilo_busy, illegal;
   logic [2:0]  state;

   int   n_chk = 0, n_pass = 0;
   int   cycn = 0, hilo_end = 0;
   logic ill = 1'b0;
   bit   h;

   mips_multicycle_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .HALT_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset), .instr(instr), .pc(pc), .waitrequest(waitrequest),
      .active(active), .state(state), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .muldiv_start(muldiv_start), .hilo_busy(hilo_busy), .illegal(illegal));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%b want=%b", tag, cycn, obs, exp);
   endtask

   // one clock: drive waitrequest, compare every output against expectation, advance
   task automatic tick(input string tag, input logic [2:0] st, input logic mr, input logic mw,
                       input logic irw, input logic pcw, input logic rw, input logic ms,
                       input logic wr);
      logic busy;
      waitrequest = wr;
      #1;
      busy = (cycn < hilo_end);
      check(tag, {active, state, mem_read, mem_write, ir_write, pc_write, reg_write,
                  muldiv_start, hilo_busy, illegal},
                 {st != 3'd7, st, mr, mw, irw, pcw, rw, ms, busy, ill});
      @(negedge clk);
      cycn++;
   endtask

   task automatic do_reset(input logic [2:0] st_now);
      reset = 1'b1;
      tick("reset", st_now, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      reset    = 1'b0;
      hilo_end = cycn;
      ill      = 1'b0;
   endtask

   function automatic int kind_of(input logic [31:0] w);
      logic [5:0] op, fn;
      logic [4:0] rt;
      op = w[31:26]; fn = w[5:0]; rt = w[20:16];
      if (op == 6'd0) begin
         if (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07})
            return K_ALU;
         if (fn == 6'h08) return K_J;
         if (fn == 6'h09) return K_JL;
         if (fn inside {6'h10, 6'h12}) return K_MF;
         if (fn inside {6'h11, 6'h13}) return K_MT;
         if (fn inside {6'h18, 6'h19}) return K_MUL;
         if (fn inside {6'h1A, 6'h1B}) return K_DIV;
         return K_ILL;
      end
      if (op == 6'd1) return (rt <= 5'd1) ? K_J : (rt inside {5'd16, 5'd17}) ? K_JL : K_ILL;
      if (op inside {6'd2, [6'd4:6'd7]}) return K_J;
      if (op == 6'd3) return K_JL;
      if (op inside {[6'd8:6'd15]}) return K_ALU;
      if (op inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37}) return K_LOAD;
      if (op inside {6'd40, 6'd41, 6'd43}) return K_STORE;
      return K_ILL;
   endfunction

   function automatic logic [4:0] dest_of(input logic [31:0] w, input int k);
      if (k == K_MF || (k == K_ALU && w[31:26] == 6'd0) || (k == K_JL && w[31:26] == 6'd0))
         return w[15:11];
      if (k == K_ALU || k == K_LOAD) return w[20:16];
      if (k == K_JL) return 5'd31;
      return 5'd0;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] tmpl [24] = '{32'h0000_0021, 32'h0000_0000, 32'h0000_0008, 32'h0000_0009,
         32'h0000_0010, 32'h0000_0012, 32'h0000_0011, 32'h0000_0013, 32'h0000_0018,
         32'h0000_0019, 32'h0000_001A, 32'h0000_001B, 32'h0000_002A, 32'h0400_0000,
         32'h0411_0000, 32'h0800_0000, 32'h0C00_0000, 32'h1000_0000, 32'h2000_0000,
         32'h3C00_0000, 32'h8C00_0000, 32'h9000_0000, 32'hAC00_0000, 32'hA000_0000};
      logic [31:0] t, mask;
      t    = tmpl[$urandom_range(0, 23)];
      mask = (t[31:26] == 6'd0) ? 32'h03FF_F800 :
             (t[31:26] == 6'd1) ? 32'h03E0_FFFF : 32'h03FF_FFFF;
      return t | ($urandom() & mask);
   endfunction

   // expected cycle-by-cycle timeline of one instruction
   task automatic run_instr(input logic [31:0] w, input logic [31:0] pcv, input int wf,
                            input int wm, input bit abort, input string tag, output bit halted);
      int   k, t;
      logic rwb;
      instr  = w;
      pc     = pcv;
      halted = 1'b0;
      if (pcv == 32'd0) begin
         tick({tag, "/fetch0"}, 0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
         repeat (3) tick({tag, "/halt"}, 7, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
         halted = 1'b1;
         return;
      end
      repeat (wf) tick({tag, "/fetchw"}, 0, 1, 0, 0, 0, 0, 0, 1);
      tick({tag, "/fetch"}, 0, 1, 0, 1, 0, 0, 0, 0);
      tick({tag, "/decode"}, 1, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      k = kind_of(w);
      if (k == K_ILL) begin
         ill = 1'b1;
         repeat (3) tick({tag, "/illhalt"}, 7, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
         halted = 1'b1;
         return;
      end
      if (k inside {K_MUL, K_DIV, K_MF, K_MT})
         while (cycn < hilo_end) tick({tag, "/stall"}, 2, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      rwb = (dest_of(w, k) != 5'd0);
      case (k)
         K_ALU, K_MF, K_JL: begin
            tick({tag, "/exec"}, 2, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            tick({tag, "/wb"}, 4, 0, 0, 0, 1, rwb, 0, 1'($urandom_range(0, 1)));
         end
         K_J, K_MT: tick({tag, "/exec"}, 2, 0, 0, 0, 1, 0, 0, 1'($urandom_range(0, 1)));
         K_MUL, K_DIV: begin
            t = cycn;
            tick({tag, "/issue"}, 2, 0, 0, 0, 1, 0, 1, 1'($urandom_range(0, 1)));
            hilo_end = t + 1 + ((k == K_MUL) ? MULT_N : DIV_N);
         end
         K_LOAD: begin
            tick({tag, "/exec"}, 2, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            repeat (wm) tick({tag, "/memw"}, 3, 1, 0, 0, 0, 0, 0, 1);
            tick({tag, "/mem"}, 3, 1, 0, 0, 0, 0, 0, 0);
            tick({tag, "/wb"}, 4, 0, 0, 0, 1, rwb, 0, 1'($urandom_range(0, 1)));
         end
         default: begin
            tick({tag, "/exec"}, 2, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            repeat (wm) tick({tag, "/memw"}, 3, 0, 1, 0, 0, 0, 0, 1);
            if (abort) do_reset(3);
            else tick({tag, "/mem"}, 3, 0, 1, 0, 1, 0, 0, 0);
         end
      endcase
   endtask

   initial begin
      reset = 1'b1; waitrequest = 1'b0; instr = 32'd0; pc = 32'h400;
      @(negedge clk);
      @(negedge clk);
      do_reset(0);
      run_instr(32'h0000_0000, 32'h0, 0, 0, 0, "pc0", h);
      do_reset(7);
      run_instr(32'h0085_1021, 32'h400, 0, 0, 0, "addu", h);
      run_instr(32'h8C82_0004, 32'h404, 1, 3, 0, "lw", h);
      run_instr(32'h0085_0018, 32'h408, 0, 0, 0, "mult", h);
      run_instr(32'h0000_1012, 32'h40C, 0, 0, 0, "mflo", h);
      run_instr(32'h0085_0021, 32'h410, 0, 0, 0, "addu0", h);
      run_instr(32'hAC82_0000, 32'h414, 2, 2, 0, "sw", h);
      run_instr(32'hFC00_0000, 32'h418, 0, 0, 0, "ill", h);
      do_reset(7);
      run_instr(32'h0085_001A, 32'h400, 0, 0, 0, "div", h);
      run_instr(32'hAC82_0000, 32'h404, 0, 2, 1, "swrst", h);
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 25; i++)
            run_instr(rand_instr(), 32'h1000 + 32'(4 * i), $urandom_range(0, 2),
                      $urandom_range(0, 2), 0, "rnd", h);
         if (p % 2 == 0) run_instr(rand_instr(), 32'h0, 0, 0, 0, "rndpc0", h);
         else            run_instr(32'h0000_0001 | ($urandom() & 32'h03FF_F800), 32'h2000,
                                   1, 0, 0, "rndill", h);
         do_reset(7);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
